// File: rtl/ysyx_23060203_lsu_pkg.sv
// Shared constants for the ysyx_23060203 load/store unit: funct3 access codes,
// AXI response encoding and the transaction FSM state type.
package ysyx_23060203_lsu_pkg;

  localparam logic [2:0] LS_B  = 3'd0;
  localparam logic [2:0] LS_H  = 3'd1;
  localparam logic [2:0] LS_W  = 3'd2;
  localparam logic [2:0] LS_BU = 3'd4;
  localparam logic [2:0] LS_HU = 3'd5;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WRITE,
    S_WRESP,
    S_DONE
  } state_t;

endpackage

// File: rtl/ysyx_23060203_lsu_align.sv
// Byte-lane steering for a 32-bit bus: store strobe/data shift, load lane
// extraction with sign/zero extension, and access legality (funct + alignment).
module ysyx_23060203_lsu_align
  import ysyx_23060203_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                is_load,
  input  logic [2:0]          func,
  input  logic [1:0]          off,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   wdata_sh,
  output logic [DATA_W-1:0]   rdata_ext,
  output logic                bad
);

  logic [DATA_W/8-1:0] strb_base;
  logic [DATA_W-1:0]   lane;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a latch.
    strb_base = '0;
    rdata_ext = '0;
    bad       = 1'b1;
    wdata_sh  = wdata << {off, 3'b000};
    lane      = rdata >> {off, 3'b000};
    unique case (func)
      LS_B: begin
        strb_base = 4'b0001;
        rdata_ext = {{24{lane[7]}}, lane[7:0]};
        bad       = 1'b0;
      end
      LS_H: begin
        strb_base = 4'b0011;
        rdata_ext = {{16{lane[15]}}, lane[15:0]};
        bad       = off[0];
      end
      LS_W: begin
        strb_base = 4'b1111;
        rdata_ext = lane;
        bad       = (off != 2'b00);
      end
      // Unsigned variants exist only for loads.
      LS_BU: begin
        rdata_ext = {24'b0, lane[7:0]};
        bad       = !is_load;
      end
      LS_HU: begin
        rdata_ext = {16'b0, lane[15:0]};
        bad       = !is_load || off[0];
      end
      default: bad = 1'b1;
    endcase
    wstrb = strb_base << off;
  end

endmodule

// File: rtl/ysyx_23060203_lsu.sv
// Load/store unit: runs each execute-stage memory request as one AXI4-Lite
// master transaction and returns a single completion pulse with data/error.
module ysyx_23060203_lsu
  import ysyx_23060203_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_ren,
  input  logic                in_wen,
  input  logic [2:0]          in_func,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_rdata,
  output logic                out_err,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  state_t              state;
  logic [2:0]          func_q;
  logic [1:0]          off_q;
  logic [2:0]          func_sel;
  logic [1:0]          off_sel;
  logic                is_load;
  logic [DATA_W/8-1:0] strb_al;
  logic [DATA_W-1:0]   wdata_al;
  logic [DATA_W-1:0]   rdata_al;
  logic                bad;

  // In IDLE the aligner judges the incoming request; afterwards it serves the latched load.
  assign func_sel = (state == S_IDLE) ? in_func       : func_q;
  assign off_sel  = (state == S_IDLE) ? in_addr[1:0]  : off_q;
  assign is_load  = (state == S_IDLE) ? in_ren        : 1'b1;

  ysyx_23060203_lsu_align #(.DATA_W(DATA_W)) u_align (
    .is_load   (is_load),
    .func      (func_sel),
    .off       (off_sel),
    .wdata     (in_wdata),
    .rdata     (m_rdata),
    .wstrb     (strb_al),
    .wdata_sh  (wdata_al),
    .rdata_ext (rdata_al),
    .bad       (bad)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      func_q    <= '0;
      off_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_rdata <= '0;
      out_err   <= 1'b0;
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          func_q   <= in_func;
          off_q    <= in_addr[1:0];
          if (!in_ren && !in_wen) begin
            out_valid <= 1'b1;
            out_rdata <= '0;
            out_err   <= 1'b0;
            state     <= S_DONE;
          end else if (bad) begin
            out_valid <= 1'b1;
            out_rdata <= '0;
            out_err   <= 1'b1;
            state     <= S_DONE;
          end else if (in_ren) begin
            m_araddr  <= {in_addr[ADDR_W-1:2], 2'b00};
            m_arvalid <= 1'b1;
            state     <= S_RADDR;
          end else begin
            m_awaddr  <= {in_addr[ADDR_W-1:2], 2'b00};
            m_awvalid <= 1'b1;
            m_wdata   <= wdata_al;
            m_wstrb   <= strb_al;
            m_wvalid  <= 1'b1;
            state     <= S_WRITE;
          end
        end
        S_RADDR: if (m_arready) begin
          m_arvalid <= 1'b0;
          m_rready  <= 1'b1;
          state     <= S_RDATA;
        end
        S_RDATA: if (m_rvalid) begin
          m_rready  <= 1'b0;
          out_valid <= 1'b1;
          out_err   <= (m_rresp != RESP_OKAY);
          out_rdata <= (m_rresp != RESP_OKAY) ? '0 : rdata_al;
          state     <= S_DONE;
        end
        S_WRITE: begin
          // AW and W complete independently; leave once neither is still outstanding.
          if (m_awvalid && m_awready) m_awvalid <= 1'b0;
          if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
          if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
            m_bready <= 1'b1;
            state    <= S_WRESP;
          end
        end
        S_WRESP: if (m_bvalid) begin
          m_bready  <= 1'b0;
          out_valid <= 1'b1;
          out_err   <= (m_bresp != RESP_OKAY);
          out_rdata <= '0;
          state     <= S_DONE;
        end
        S_DONE: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_lsu.sv
// Self-checking bench for ysyx_23060203_lsu: AXI4-Lite slave model with
// configurable AW wait and error responses, scoreboard of completions.
module tb_ysyx_23060203_lsu;
  import ysyx_23060203_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0, in_ren = 1'b0, in_wen = 1'b0;
  logic [2:0]  in_func = '0;
  logic [31:0] in_addr = '0, in_wdata = '0;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_rdata;
  logic [31:0] m_araddr, m_awaddr, m_wdata;
  logic        m_arvalid, m_arready, m_rready, m_awvalid, m_awready, m_wvalid, m_wready, m_bready;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp, m_bresp;
  logic        m_rvalid, m_bvalid;

  always #5 clk = ~clk;

  ysyx_23060203_lsu dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
    .in_func(in_func), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_rdata(out_rdata), .out_err(out_err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  // ---------------- slave model ----------------
  logic [31:0] mem [0:15] = '{0: 32'h11223380, 1: 32'h11223380, 3: 32'h80017F55, default: 32'h0};
  int          aw_wait = 0;
  logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
  int          aw_cnt;
  int          ar_cnt = 0;
  int          cyc = 0;
  logic        aw_got, w_got;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;

  assign m_arready = 1'b1;
  assign m_wready  = 1'b1;
  assign m_awready = (aw_cnt >= aw_wait);

  wire         aw_fire = m_awvalid & m_awready;
  wire         w_fire  = m_wvalid & m_wready;
  wire [31:0]  wr_addr = aw_got ? s_awaddr : m_awaddr;
  wire [31:0]  wr_data = w_got ? s_wdata : m_wdata;
  wire [3:0]   wr_strb = w_got ? s_wstrb : m_wstrb;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (m_arvalid) ar_cnt <= ar_cnt + 1;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0;
      m_bvalid <= 1'b0; m_bresp <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
    end else begin
      if (m_arvalid && m_arready) begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem[m_araddr[5:2]];
        m_rresp  <= rresp_cfg;
      end else if (m_rvalid && m_rready) begin
        m_rvalid <= 1'b0;
      end
      if (m_awvalid && !m_awready) aw_cnt <= aw_cnt + 1;
      else aw_cnt <= 0;
      if (aw_fire) begin aw_got <= 1'b1; s_awaddr <= m_awaddr; end
      if (w_fire) begin w_got <= 1'b1; s_wdata <= m_wdata; s_wstrb <= m_wstrb; end
      if ((aw_got || aw_fire) && (w_got || w_fire) && !m_bvalid) begin
        mem[wr_addr[5:2]] <= merge(mem[wr_addr[5:2]], wr_data, wr_strb);
        m_bvalid <= 1'b1;
        m_bresp  <= bresp_cfg;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else if (m_bvalid && m_bready) begin
        m_bvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && out_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got out_valid=1 with no request pending, expected none");
        end else begin
          e = sb.pop_front();
          check({e.name, "_rdata"}, out_rdata, e.rdata);
          check({e.name, "_err"}, {31'b0, out_err}, {31'b0, e.err});
          check({e.name, "_latency"}, cyc - e.acc + 1, e.lat);
        end
      end
    end
  end

  task automatic issue(input string name, input logic ren, input logic wen, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd, input logic push,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat);
    int g;
    exp_t e;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check({name, "_in_ready_before_issue"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_ren = ren; in_wen = wen; in_func = f; in_addr = a; in_wdata = wd;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0;
    if (push) begin
      e.name = name; e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !in_ready) && g < 100) begin
      @(negedge clk);
      g++;
    end
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int snap;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_out_rdata", out_rdata, 32'd0);
    check("rst_valids", {27'b0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 32'd0);
    check("rst_addrs", m_araddr | m_awaddr | m_wdata | {28'b0, m_wstrb}, 32'd0);
    rstn = 1'b1;

    // Test 1: lb sign extension, zero-wait latency 3
    issue("t1_lb", 1, 0, LS_B, 32'h80000004, 0, 1, 32'hFFFFFF80, 0, 3);
    @(negedge clk);
    check("t1_araddr", m_araddr, 32'h80000004);
    check("t1_arvalid", {31'b0, m_arvalid}, 32'd1);
    issue("t1_lbu", 1, 0, LS_BU, 32'h80000004, 0, 1, 32'h00000080, 0, 3);

    // Test 2: sh lane shift and strobes
    issue("t2_sh", 0, 1, LS_H, 32'h80000002, 32'h0000ABCD, 1, 32'h0, 0, 3);
    @(negedge clk);
    check("t2_awaddr", m_awaddr, 32'h80000000);
    check("t2_wstrb", {28'b0, m_wstrb}, 32'h0000000C);
    check("t2_wdata", m_wdata, 32'hABCD0000);
    check("t2_aw_w_valid", {30'b0, m_awvalid, m_wvalid}, 32'd3);
    wait_idle("t2");
    check("t2_mem_word", mem[0], 32'hABCD3380);
    issue("t2_lw_back", 1, 0, LS_W, 32'h80000000, 0, 1, 32'hABCD3380, 0, 3);

    // Test 3: misaligned lw, no bus traffic
    wait_idle("t3_pre");
    snap = ar_cnt;
    issue("t3_lw_mis", 1, 0, LS_W, 32'h80000001, 0, 1, 32'h0, 1, 1);
    wait_idle("t3");
    check("t3_no_arvalid", ar_cnt - snap, 32'd0);

    // Test 4: awready 3 cycles late, wready immediate
    aw_wait = 3;
    issue("t4_sw", 0, 1, LS_W, 32'h80000008, 32'hDEADBEEF, 1, 32'h0, 0, 6);
    @(negedge clk);
    check("t4_c1_valids", {30'b0, m_awvalid, m_wvalid}, 32'd3);
    @(negedge clk);
    check("t4_c2_valids", {30'b0, m_awvalid, m_wvalid}, 32'd2);
    @(negedge clk);
    check("t4_c3_awvalid", {31'b0, m_awvalid}, 32'd1);
    @(negedge clk);
    check("t4_c4_aw_handshake", {30'b0, m_awvalid, m_awready}, 32'd3);
    @(negedge clk);
    check("t4_c5_awvalid_low", {31'b0, m_awvalid}, 32'd0);
    wait_idle("t4");
    aw_wait = 0;
    issue("t4_lw_back", 1, 0, LS_W, 32'h80000008, 0, 1, 32'hDEADBEEF, 0, 3);

    // Test 5: lhu with SLVERR, in_ready timing
    wait_idle("t5_pre");
    rresp_cfg = 2'b10;
    issue("t5_lhu_err", 1, 0, LS_HU, 32'h80000006, 0, 1, 32'h0, 1, 3);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("t5_in_ready_busy", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    check("t5_in_ready_after", {31'b0, in_ready}, 32'd1);
    rresp_cfg = 2'b00;

    // Extension and legality vectors
    issue("x_lh", 1, 0, LS_H, 32'h8000000E, 0, 1, 32'hFFFF8001, 0, 3);
    issue("x_lhu", 1, 0, LS_HU, 32'h8000000E, 0, 1, 32'h00008001, 0, 3);
    issue("x_lb_pos", 1, 0, LS_B, 32'h8000000D, 0, 1, 32'h0000007F, 0, 3);
    issue("x_lb_lane0", 1, 0, LS_B, 32'h8000000C, 0, 1, 32'h00000055, 0, 3);
    issue("x_lbu_lane3", 1, 0, LS_BU, 32'h8000000F, 0, 1, 32'h00000080, 0, 3);
    issue("x_ld_f3", 1, 0, 3'd3, 32'h80000000, 0, 1, 32'h0, 1, 1);
    issue("x_lw_ok", 1, 0, LS_W, 32'h80000004, 0, 1, 32'h11223380, 0, 3);
    issue("x_st_f4", 0, 1, LS_BU, 32'h80000000, 32'h1, 1, 32'h0, 1, 1);
    issue("x_sh_mis", 0, 1, LS_H, 32'h80000001, 32'h1, 1, 32'h0, 1, 1);
    issue("x_lw_ok2", 1, 0, LS_W, 32'h80000004, 0, 1, 32'h11223380, 0, 3);
    issue("x_none", 0, 0, LS_W, 32'h80000004, 0, 1, 32'h0, 0, 1);
    issue("x_ren_wen", 1, 1, LS_W, 32'h80000004, 32'h0, 1, 32'h11223380, 0, 3);
    wait_idle("x_pre_bresp");
    bresp_cfg = 2'b11;
    issue("x_sb_berr", 0, 1, LS_B, 32'h80000005, 32'h0000005A, 1, 32'h0, 1, 3);
    wait_idle("x_bresp");
    bresp_cfg = 2'b00;
    check("x_sb_mem", mem[1], 32'h11225A80);

    // Test 6: reset while RDATA has rvalid pending
    issue("t6_abandon", 1, 0, LS_W, 32'h80000004, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("t6_pending", {30'b0, m_rready, m_rvalid}, 32'd3);
    rstn = 1'b0;
    #1;
    check("t6_rready", {31'b0, m_rready}, 32'd0);
    check("t6_out_valid", {31'b0, out_valid}, 32'd0);
    check("t6_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    issue("t6_lw_after", 1, 0, LS_W, 32'h80000008, 0, 1, 32'hDEADBEEF, 0, 3);
    wait_idle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
